mult_nxn_seq_approx: RTL
========================

// Module: mult_nxn_seq_approx
// PURPOSE
//  Parametrised, multi-cycle successor to the 8x8 OR-combined approximate multiplier.
//  Splits A and B (N bits each) into 4-bit digits and forms one 4x4 partial product per cycle.
//  Accumulates the shifted partial products either exactly (add) or approximately (bitwise OR),
//  selected per operation. Sits behind a valid/ready stream in the error-characterisation datapath.
// PARAMETERS
//  N          8   operand width; multiple of 4, range 4..32
//  TRUNC_BLK  0   blocks with (ai+bj) < TRUNC_BLK contribute zero (column truncation); 0 = none
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous reset, active-high
//  in_valid   in   1    operand request
//  in_ready   out  1    block can accept operands
//  A          in   N    multiplicand (unsigned)
//  B          in   N    multiplier (unsigned)
//  MODE       in   1    0 = exact add accumulation, 1 = OR-combine (approximate)
//  out_valid  out  1    R holds a finished result
//  out_ready  in   1    consumer takes result
//  R          out  2N   product (exact or approximate)
// BEHAVIOUR
//  - D = N/4 digits; K = D*D blocks; block index k = 0..K-1, ai = k % D, bj = k / D.
//  - pp(k) = A[4ai+3:4ai] * B[4bj+3:4bj], exact 8-bit; shifted left by 4*(ai+bj) into 2N bits.
//  - Accumulator ACC (2N bits): MODE=0 ACC <= ACC + pp_shifted (mod 2^2N, no overflow possible);
//    MODE=1 ACC <= ACC | pp_shifted. Truncated blocks: pp_shifted = 0, still take one cycle.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//    IDLE: in_ready=1, out_valid=0. in_valid&in_ready at edge: latch A, B, MODE; ACC<=0; k<=0; ->CALC.
//    CALC: in_ready=0. One block per cycle; k increments; after block K-1 is accumulated -> DONE.
//    DONE: out_valid=1, R=ACC, stable while out_ready=0. out_valid&out_ready at edge -> IDLE.
//  - Latency: handshake accepted at edge t; out_valid rises after edge t+K (R valid at the same time).
//  - Throughput: one op per K+2 cycles minimum; no new accept in CALC or DONE (in_ready=0).
//  - A/B/MODE changes while not in IDLE are ignored (operands are latched).
//  - out_ready high in IDLE/CALC has no effect; in_valid held high after an accept does not
//    start a second op until IDLE is re-entered.
//  - Reset (any state, incl. mid-CALC): state=IDLE, in_ready=1, out_valid=0, R=0, ACC=0, k=0;
//    the in-flight operation is discarded and never reported.
//  - Outputs registered; R driven from ACC register, no combinational path from inputs to outputs
//    except none (in_ready is state-decoded only).
//  - N=8, MODE=1, TRUNC_BLK=0 reproduces the 8x8 OR-combined result with exact 4x4 sub-products.
// TESTING
//  - N=8, MODE=0, A=0xFF, B=0xFF -> R=0xFE01 (65025); out_valid 4 cycles after accept.
//  - N=8, MODE=1, A=0xFF, B=0xFF -> R=0xEFF1 (0x00E1|0x0E10|0x0E10|0xE100).
//  - N=16, MODE=0, A=0xFFFF, B=0xFFFF -> R=0xFFFE0001 after 16 CALC cycles; in_ready low throughout.
//  - N=8, TRUNC_BLK=1, MODE=0: A=0x0F, B=0x0F -> R=0; A=0xF0, B=0x0F -> R=0x0E10 (3600).
//  - Backpressure: hold out_ready=0 for 3 cycles in DONE -> R/out_valid stable; in_valid ignored;
//    release -> IDLE next edge, in_ready=1.
//  - Assert rst for 1 cycle at k=2 of a 4-block op -> out_valid never rises for that op; next op
//    A=3, B=5, MODE=0 -> R=15.

Source files
------------

// File: rtl/mult_nxn_seq_approx.sv
// Sequential NxN approximate multiplier: one 4x4 digit product per cycle, accumulated
// either exactly (add) or approximately (bitwise OR), behind valid/ready handshakes.
module mult_nxn_seq_approx #(
    parameter int N         = 8,
    parameter int TRUNC_BLK = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic           MODE,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] R
);

    localparam int D  = N / 4;
    localparam int K  = D * D;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = DW + 2;

    localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(D - 1);
    localparam logic [SW-1:0] TRUNC_V = SW'(TRUNC_BLK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            mode_q;
    logic [2*N-1:0]  acc_q;
    logic [DW-1:0]   ai_q;
    logic [DW-1:0]   bj_q;
    logic [KW-1:0]   k_q;

    logic [N-1:0]    a_sh_s;
    logic [N-1:0]    b_sh_s;
    logic [7:0]      pp_s;
    logic [SW-1:0]   pos_s;
    logic [2*N-1:0]  pp_ext_s;
    logic [2*N-1:0]  blk_s;
    logic            last_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            S_CALC: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Current digit product, placed at its column; low columns dropped when truncating
    always_comb begin
        a_sh_s   = a_q >> {ai_q, 2'b00};
        b_sh_s   = b_q >> {bj_q, 2'b00};
        pp_s     = {4'b0000, a_sh_s[3:0]} * {4'b0000, b_sh_s[3:0]};
        pos_s    = {2'b00, ai_q} + {2'b00, bj_q};
        pp_ext_s = (2*N)'(pp_s);
        last_s   = (k_q == K_LAST);
        if (pos_s < TRUNC_V) begin
            blk_s = {(2*N){1'b0}};
        end else begin
            blk_s = pp_ext_s << {pos_s, 2'b00};
        end
    end

    // Operand latch, digit counters and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= {N{1'b0}};
            b_q    <= {N{1'b0}};
            mode_q <= 1'b0;
            acc_q  <= {(2*N){1'b0}};
            ai_q   <= {DW{1'b0}};
            bj_q   <= {DW{1'b0}};
            k_q    <= {KW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        mode_q <= MODE;
                        acc_q  <= {(2*N){1'b0}};
                        ai_q   <= {DW{1'b0}};
                        bj_q   <= {DW{1'b0}};
                        k_q    <= {KW{1'b0}};
                    end
                end
                S_CALC: begin
                    if (mode_q) begin
                        acc_q <= acc_q | blk_s;
                    end else begin
                        acc_q <= acc_q + blk_s;
                    end
                    k_q <= k_q + 1'b1;
                    if (ai_q == D_LAST) begin
                        ai_q <= {DW{1'b0}};
                        bj_q <= bj_q + 1'b1;
                    end else begin
                        ai_q <= ai_q + 1'b1;
                    end
                end
                S_DONE: begin
                    acc_q <= acc_q;
                end
                default: begin
                    acc_q <= acc_q;
                end
            endcase
        end
    end

    assign R = acc_q;

endmodule
